router_port: RTL

Router-side endpoint of the node↔router byte-serial link: the counterpart of the node's outbound and inbound byte handshakes. It deserializes 4-byte packets arriving from its attached node into a small packet buffer, which it presents to the router core with valid/ready. It also accepts packets from the router core and serializes them to the node. One instance sits on each node-facing port of the router.

---
 rtl/noc_pkg.sv | 37 +++
 rtl/pkt_buffer.sv | 62 ++++++
 rtl/router_port.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: types and constants shared by the node<->router byte-serial link.
//   pkt_t       : 32-bit packet {sourceID, destID, data}
//   PKT_BYTES   : bytes per packet on the serial link
//   tx_state_t  : outbound serializer states
//   pkt_byte()  : byte N of a packet in wire order
package noc_pkg;

  typedef struct packed {
    logic [3:0]  sourceID;
    logic [3:0]  destID;
    logic [23:0] data;
  } pkt_t;

  localparam int PKT_BYTES = 4;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SEND0,
    TX_SEND1,
    TX_SEND2,
    TX_SEND3,
    TX_GAP
  } tx_state_t;

  // Wire order: byte0 = {sourceID, destID}, then data MSB first.
  function automatic logic [7:0] pkt_byte(input pkt_t p, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {p.sourceID, p.destID};
      2'd1:    b = p.data[23:16];
      2'd2:    b = p.data[15:8];
      default: b = p.data[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pkt_buffer.sv
// pkt_buffer: small FIFO of pkt_t entries with a combinational head.
//   clock, reset_b : clock, asynchronous active-low reset
//   push, push_pkt : write an entry (ignored when full)
//   pop            : drop the head entry (ignored when empty)
//   head           : oldest entry, all-zero when empty
//   used           : number of valid entries 0..DEPTH
//   full, empty    : occupancy flags
module pkt_buffer
  import noc_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int UW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          reset_b,
  input  logic          push,
  input  pkt_t          push_pkt,
  input  logic          pop,
  output pkt_t          head,
  output logic [UW-1:0] used,
  output logic          full,
  output logic          empty
);

  localparam logic [UW-1:0] DEPTH_U = UW'(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

  pkt_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (used == DEPTH_U);
  assign empty   = (used == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? pkt_t'('0) : mem[rd_ptr];

  // Storage carries data only; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_pkt;
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase
    end
  end

endmodule

// File: rtl/router_port.sv
// router_port: router-side endpoint of the node<->router byte-serial link.
//   clock, reset_b      : clock, asynchronous active-low reset
//   put_from_node,
//   payload_from_node   : inbound byte stream from the node
//   free_to_node        : node may start an inbound packet this cycle
//   put_to_node,
//   payload_to_node     : outbound byte stream to the node (0 when idle)
//   free_from_node      : node can accept the start of an outbound packet
//   rx_pkt/rx_valid/
//   rx_ready            : buffered inbound packets to the router core
//   tx_pkt/tx_valid/
//   tx_ready            : outbound packets from the router core
//   proto_err           : sticky flag, node broke the inbound handshake
module router_port
  import noc_pkg::*;
#(
  parameter int RXDEPTH = 2
) (
  input  logic       clock,
  input  logic       reset_b,
  input  logic       put_from_node,
  input  logic [7:0] payload_from_node,
  output logic       free_to_node,
  output logic       put_to_node,
  output logic [7:0] payload_to_node,
  input  logic       free_from_node,
  output pkt_t       rx_pkt,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  pkt_t       tx_pkt,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       proto_err
);

  localparam int UW = $clog2(RXDEPTH + 1);

  logic [1:0]    byte_cnt;
  logic [23:0]   rx_hold;
  logic          proto_err_q;
  logic          rx_push;
  pkt_t          rx_push_pkt;
  logic          rx_pop;
  logic [UW-1:0] rx_used;
  logic          rx_full;
  logic          rx_empty;

  tx_state_t     tx_state;
  tx_state_t     tx_state_nxt;
  pkt_t          tx_lat;
  logic          tx_load;

  // ---- inbound deserializer ----
  // Only registered state feeds free_to_node, so the node never sees a
  // combinational path from its own put. Space is reserved before byte0
  // is accepted, which is why the push below can never overflow.
  assign free_to_node = (byte_cnt == 2'd0) && !rx_full;
  assign rx_push      = (byte_cnt == 2'd3) && put_from_node;
  assign rx_push_pkt  = pkt_t'({rx_hold, payload_from_node});
  assign proto_err    = proto_err_q;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      byte_cnt    <= 2'd0;
      rx_hold     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      case (byte_cnt)
        2'd0: begin
          if (put_from_node) begin
            if (free_to_node) begin
              rx_hold[23:16] <= payload_from_node;
              byte_cnt       <= 2'd1;
            end else begin
              proto_err_q <= 1'b1;
            end
          end
        end
        2'd1: begin
          rx_hold[15:8] <= payload_from_node;
          if (put_from_node) begin
            byte_cnt <= 2'd2;
          end else begin
            proto_err_q <= 1'b1;
            byte_cnt    <= 2'd0;
          end
        end
        2'd2: begin
          rx_hold[7:0] <= payload_from_node;
          if (put_from_node) begin
            byte_cnt <= 2'd3;
          end else begin
            proto_err_q <= 1'b1;
            byte_cnt    <= 2'd0;
          end
        end
        default: begin
          byte_cnt <= 2'd0;
          if (!put_from_node) proto_err_q <= 1'b1;
        end
      endcase
    end
  end

  // ---- inbound buffer ----
  assign rx_pop   = rx_ready && !rx_empty;
  assign rx_valid = (rx_used != '0);

  pkt_buffer #(
    .DEPTH (RXDEPTH)
  ) u_rx_buf (
    .clock    (clock),
    .reset_b  (reset_b),
    .push     (rx_push),
    .push_pkt (rx_push_pkt),
    .pop      (rx_pop),
    .head     (rx_pkt),
    .used     (rx_used),
    .full     (rx_full),
    .empty    (rx_empty)
  );

  // ---- outbound serializer ----
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      tx_state <= TX_IDLE;
      tx_lat   <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      if (tx_load) tx_lat <= tx_pkt;
    end
  end

  // SEND0 waits for the node to be free; once byte0 is out the remaining
  // bytes follow unconditionally, and GAP gives the node a cycle to present
  // the packet it has just assembled.
  always_comb begin
    tx_state_nxt    = tx_state;
    tx_ready        = 1'b0;
    tx_load         = 1'b0;
    put_to_node     = 1'b0;
    payload_to_node = 8'h00;
    case (tx_state)
      TX_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          tx_load      = 1'b1;
          tx_state_nxt = TX_SEND0;
        end
      end
      TX_SEND0: begin
        put_to_node = free_from_node;
        if (free_from_node) begin
          payload_to_node = pkt_byte(tx_lat, 2'd0);
          tx_state_nxt    = TX_SEND1;
        end
      end
      TX_SEND1: begin
        put_to_node     = 1'b1;
        payload_to_node = pkt_byte(tx_lat, 2'd1);
        tx_state_nxt    = TX_SEND2;
      end
      TX_SEND2: begin
        put_to_node     = 1'b1;
        payload_to_node = pkt_byte(tx_lat, 2'd2);
        tx_state_nxt    = TX_SEND3;
      end
      TX_SEND3: begin
        put_to_node     = 1'b1;
        payload_to_node = pkt_byte(tx_lat, 2'd3);
        tx_state_nxt    = TX_GAP;
      end
      TX_GAP: begin
        tx_state_nxt = TX_IDLE;
      end
      default: begin
        tx_state_nxt = TX_IDLE;
      end
    endcase
  end

endmodule
